// File: rtl/fifo_credit_mc.sv
// Multi-channel credit FIFO: NUM_CH virtual-channel rings behind one write port,
// drained through a round-robin arbiter that holds its grant under backpressure.
module fifo_credit_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [CH_W-1:0]              rd_ch,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [NUM_CH*(ADDR_W+1)-1:0] credit_count,
  output logic [NUM_CH-1:0]            credit_return,
  output logic                         overflow_err
);

  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   OCC_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [CH_W-1:0]   CH_ZERO  = CH_W'(0);
  localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]     CH_COUNT = (CH_W+1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] mem_r    [NUM_CH][DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_r [NUM_CH];
  logic [ADDR_W-1:0]     rd_ptr_r [NUM_CH];
  logic [ADDR_W:0]       occ_r    [NUM_CH];
  logic [CH_W-1:0]       rr_ptr_r;
  logic                  lock_r;
  logic [CH_W-1:0]       lock_ch_r;
  logic [NUM_CH-1:0]     credit_return_r;
  logic                  overflow_err_r;

  logic [NUM_CH-1:0]     nonempty_s;
  logic [NUM_CH-1:0]     wr_sel_s;
  logic [NUM_CH-1:0]     rd_sel_s;
  logic [CH_W-1:0]       grant_s;
  logic [CH_W-1:0]       next_rr_s;
  logic                  found_s;
  logic                  wr_ch_ok_s;
  logic                  wr_ready_s;
  logic                  wr_fire_s;
  logic                  pop_s;

  // Write-side acceptance: wr_ready looks only at current occupancy, never at a concurrent pop
  always_comb begin
    wr_ch_ok_s = ({1'b0, wr_ch} < CH_COUNT);
    wr_ready_s = wr_ch_ok_s && (occ_r[wr_ch] != DEPTH_V);
    wr_fire_s  = wr_valid && wr_ready_s;
  end

  // Round-robin search from rr_ptr_r, overridden by the held grant while stalled
  always_comb begin
    int unsigned idx_v;
    logic        hit_v;
    idx_v   = 0;
    hit_v   = 1'b0;
    grant_s = CH_ZERO;
    found_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty_s[c] = (occ_r[c] != OCC_ZERO);
    end
    if (lock_r) begin
      grant_s = lock_ch_r;
      found_s = nonempty_s[lock_ch_r];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx_v   = (int'(rr_ptr_r) + i >= NUM_CH) ? int'(rr_ptr_r) + i - NUM_CH
                                                 : int'(rr_ptr_r) + i;
        hit_v   = !found_s && nonempty_s[idx_v];
        grant_s = hit_v ? CH_W'(idx_v) : grant_s;
        found_s = found_s | hit_v;
      end
    end
  end

  // Per-channel strobes for this cycle's accepted write and pop
  always_comb begin
    pop_s     = found_s && rd_ready;
    next_rr_s = (grant_s == CH_LAST) ? CH_ZERO : grant_s + CH_ONE;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel_s[c] = wr_fire_s && (wr_ch == CH_W'(c));
      rd_sel_s[c] = pop_s && (grant_s == CH_W'(c));
    end
  end

  // Pointers, occupancy, arbiter state and sticky/pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        occ_r[c]    <= OCC_ZERO;
      end
      rr_ptr_r        <= CH_ZERO;
      lock_r          <= 1'b0;
      lock_ch_r       <= CH_ZERO;
      credit_return_r <= '0;
      overflow_err_r  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_sel_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE;
        if (rd_sel_s[c]) rd_ptr_r[c] <= rd_ptr_r[c] + PTR_ONE;
        case ({wr_sel_s[c], rd_sel_s[c]})
          2'b10:   occ_r[c] <= occ_r[c] + OCC_ONE;
          2'b01:   occ_r[c] <= occ_r[c] - OCC_ONE;
          default: occ_r[c] <= occ_r[c];
        endcase
      end
      if (pop_s) rr_ptr_r <= next_rr_s;
      lock_r          <= found_s && !rd_ready;
      lock_ch_r       <= grant_s;
      credit_return_r <= rd_sel_s;
      overflow_err_r  <= overflow_err_r | (wr_valid && !wr_ready_s);
    end
  end

  // Payload storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_fire_s) mem_r[wr_ch][wr_ptr_r[wr_ch]] <= wr_data;
  end

  assign wr_ready      = wr_ready_s;
  assign rd_valid      = found_s;
  assign rd_ch         = found_s ? grant_s : CH_ZERO;
  assign rd_data       = found_s ? mem_r[grant_s][rd_ptr_r[grant_s]] : {DATA_WIDTH{1'b0}};
  assign credit_return = credit_return_r;
  assign overflow_err  = overflow_err_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_credit
    assign credit_count[g*(ADDR_W+1) +: ADDR_W+1] = DEPTH_V - occ_r[g];
  end

endmodule

// File: tb/tb_fifo_credit_mc.sv
// Bench for fifo_credit_mc: directed vector table, corner-case sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_fifo_credit_mc;

  localparam int DW = 8;
  localparam int D  = 4;
  localparam int NC = 4;
  localparam int AW = 2;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic [CW-1:0]     wr_ch = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [CW-1:0]     rd_ch;
  logic [DW-1:0]     rd_data;
  logic [NC*(AW+1)-1:0] credit_count;
  logic [NC-1:0]     credit_return;
  logic              overflow_err;

  always #5 clk = ~clk;

  fifo_credit_mc #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch), .rd_data(rd_data),
    .credit_count(credit_count), .credit_return(credit_return),
    .overflow_err(overflow_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per channel plus round-robin bookkeeping
  logic [7:0] q [NC][$];
  int         rr_m;
  bit         held_m;
  int         held_ch_m;
  logic [3:0] cret_m;
  bit         ovf_m;

  typedef struct {
    logic       wv;
    int         wch;
    logic [7:0] wd;
    logic       rdy;
    logic       e_wr_ready;
    logic       e_valid;
    logic [1:0] e_ch;
    logic [7:0] e_data;
    logic [2:0] e_cred2;
    logic [3:0] e_cret;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pres_ch();
    int c;
    if (held_m) return held_ch_m;
    for (int i = 0; i < NC; i++) begin
      c = (rr_m + i) % NC;
      if (q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) q[c].delete();
    rr_m = 0; held_m = 0; held_ch_m = 0; cret_m = 4'b0000; ovf_m = 0;
  endfunction

  task automatic drive(input logic wv, input int wch, input logic [7:0] wd, input logic rdy);
    @(negedge clk);
    wr_valid = wv;
    wr_ch    = CW'(wch);
    wr_data  = wd;
    rd_ready = rdy;
    #1;
  endtask

  task automatic check_model();
    int pc;
    pc = pres_ch();
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, q[int'(wr_ch)].size() < D});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, pc >= 0});
    if (pc >= 0) begin
      chk("rd_ch", 32'(rd_ch), 32'(pc));
      chk("rd_data", 32'(rd_data), 32'(q[pc][0]));
    end
    for (int c = 0; c < NC; c++)
      chk("credit_count", 32'(credit_count[c*3 +: 3]), 32'(D - q[c].size()));
    chk("credit_return", 32'(credit_return), 32'(cret_m));
    chk("overflow_err", {31'd0, overflow_err}, {31'd0, ovf_m});
  endtask

  task automatic advance();
    int pc, wch;
    bit pop, wok, rdy;
    logic wv;
    logic [7:0] wd;
    pc  = pres_ch();
    wv  = wr_valid;
    wch = int'(wr_ch);
    wd  = wr_data;
    rdy = rd_ready;
    wok = q[wch].size() < D;
    pop = (pc >= 0) && rdy;
    @(posedge clk);
    held_m    = (pc >= 0) && !rdy;
    held_ch_m = pc;
    cret_m    = 4'b0000;
    if (pop) begin
      void'(q[pc].pop_front());
      rr_m = (pc + 1) % NC;
      cret_m[pc] = 1'b1;
    end
    if (wv) begin
      if (wok) q[wch].push_back(wd);
      else ovf_m = 1;
    end
  endtask

  task automatic step(input logic wv, input int wch, input logic [7:0] wd, input logic rdy);
    drive(wv, wch, wd, rdy);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b0; wr_ch = '0; wr_data = '0; rd_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_credit", 32'(credit_count), 32'h924);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_cret", 32'(credit_return), 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] rr_exp [5];
  int popped;

  initial begin
    // Fill ch2 with 0x10..0x13 under backpressure, then drain it
    tbl[0]  = '{1'b1, 2, 8'h10, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 3'd4, 4'b0000};
    tbl[1]  = '{1'b1, 2, 8'h11, 1'b0, 1'b1, 1'b1, 2'd2, 8'h10, 3'd3, 4'b0000};
    tbl[2]  = '{1'b1, 2, 8'h12, 1'b0, 1'b1, 1'b1, 2'd2, 8'h10, 3'd2, 4'b0000};
    tbl[3]  = '{1'b1, 2, 8'h13, 1'b0, 1'b1, 1'b1, 2'd2, 8'h10, 3'd1, 4'b0000};
    tbl[4]  = '{1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 8'h10, 3'd0, 4'b0000};
    tbl[5]  = '{1'b0, 2, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 8'h10, 3'd0, 4'b0000};
    tbl[6]  = '{1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h11, 3'd1, 4'b0100};
    tbl[7]  = '{1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h12, 3'd2, 4'b0100};
    tbl[8]  = '{1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h13, 3'd3, 4'b0100};
    tbl[9]  = '{1'b0, 2, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 3'd4, 4'b0100};
    tbl[10] = '{1'b0, 2, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 3'd4, 4'b0000};
    rr_exp = '{8'hA0, 8'hB0, 8'hD0, 8'hA1, 8'hD1};

    model_reset();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wv, tbl[i].wch, tbl[i].wd, tbl[i].rdy);
      chk("tbl_wr_ready", {31'd0, wr_ready}, {31'd0, tbl[i].e_wr_ready});
      chk("tbl_rd_valid", {31'd0, rd_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk("tbl_rd_ch", 32'(rd_ch), 32'(tbl[i].e_ch));
        chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].e_data));
      end
      chk("tbl_credit2", 32'(credit_count[8:6]), 32'(tbl[i].e_cred2));
      chk("tbl_cret", 32'(credit_return), 32'(tbl[i].e_cret));
      check_model();
      advance();
    end

    // Round-robin fairness
    do_reset();
    step(1'b1, 0, 8'hA0, 1'b0);
    step(1'b1, 0, 8'hA1, 1'b0);
    step(1'b1, 1, 8'hB0, 1'b0);
    step(1'b1, 3, 8'hD0, 1'b0);
    step(1'b1, 3, 8'hD1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 8'h00, 1'b1);
      chk("rr_valid", {31'd0, rd_valid}, 32'd1);
      chk("rr_order", 32'(rd_data), 32'(rr_exp[i]));
      check_model();
      advance();
    end

    // Grant hold under backpressure
    do_reset();
    step(1'b1, 1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 0, 8'h66, i == 3);
      chk("hold_ch", 32'(rd_ch), 32'd1);
      chk("hold_data", 32'(rd_data), 32'h55);
      check_model();
      advance();
    end
    drive(1'b0, 0, 8'h00, 1'b0);
    chk("hold_next_ch", 32'(rd_ch), 32'd0);
    chk("hold_next_data", 32'(rd_data), 32'h66);
    check_model();
    advance();

    // Full write concurrent with a pop of the same channel
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 0, 8'(8'h80 + i), 1'b0);
    drive(1'b1, 0, 8'hEE, 1'b1);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    check_model();
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 8'h00, 1'b0);
      chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
      chk("ovf_credit0", 32'(credit_count[2:0]), 32'd1);
      check_model();
      advance();
    end

    // Write and pop of the same non-full channel
    do_reset();
    step(1'b1, 1, 8'h21, 1'b0);
    step(1'b1, 1, 8'h22, 1'b0);
    drive(1'b1, 1, 8'h23, 1'b1);
    chk("simul_credit1_pre", 32'(credit_count[5:3]), 32'd2);
    check_model();
    advance();
    drive(1'b0, 1, 8'h00, 1'b0);
    chk("simul_credit1_post", 32'(credit_count[5:3]), 32'd2);
    chk("simul_next_data", 32'(rd_data), 32'h22);
    check_model();
    advance();

    // Ten write/read pairs on ch3 wrap the pointers
    do_reset();
    popped = 0;
    for (int k = 0; k < 11; k++) begin
      drive(k < 10, 3, 8'(8'h30 + k), 1'b1);
      if (rd_valid) begin
        chk("wrap_data", 32'(rd_data), 32'(8'h30 + popped));
        popped++;
      end
      check_model();
      advance();
    end
    chk("wrap_count", 32'(popped), 32'd10);

    // Asynchronous reset between clock edges
    do_reset();
    step(1'b1, 0, 8'h01, 1'b0);
    step(1'b1, 1, 8'h02, 1'b0);
    step(1'b1, 2, 8'h03, 1'b0);
    drive(1'b1, 3, 8'h77, 1'b0);
    check_model();
    advance();
    #3;
    rst = 1'b1;
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("async_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_credit", 32'(credit_count), 32'h924);
    chk("async_cret", 32'(credit_return), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 3)), 8'($urandom),
           ($urandom % 100) < 40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
